serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop adds two WIDTH-bit operands LSB-first, one bit per clock. It uses a start/busy/done handshake and trades latency for area in wide datapath adds. It generalises the single-bit combinational full adder to N bits with sequential control.

Parameters:
WIDTH, 8, operand/result width in bits (legal range >= 1)

Ports:
clk    input   1      system clock, rising-edge active
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled on rising clk edge; accepted only in IDLE or DONE
a      input   WIDTH  operand A; captured when start is accepted
b      input   WIDTH  operand B; captured when start is accepted
cin    input   1      carry-in; captured when start is accepted
busy   output  1      high while in RUN
done   output  1      one-cycle pulse; sum/cout valid from this cycle on
sum    output  WIDTH  result, registered; holds until the next completion
cout   output  1      carry-out of the MSB, registered; holds with sum

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). On rst_n=0, regardless of clk:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal operand shift registers, carry FF and bit counter cleared
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on accepted start.
  - RUN -> DONE after WIDTH bit-steps.
  - DONE -> IDLE after one cycle, or DONE -> RUN if start=1 in that cycle (back-to-back).
- Accepting start (edge E0):
  - latch a and b into shift registers
  - carry FF <= cin
  - counter <= 0
  - state <= RUN
- Each RUN edge:
  - s_i = a0 ^ b0 ^ c
  - c <= (a0 & b0) | ((a0 ^ b0) & c)
  - shift a and b right by 1
  - shift s_i into the MSB of the internal result register
  - counter++
- On the edge where counter reaches WIDTH-1 (edge E0+WIDTH):
  - sum <= completed result; cout <= final carry
  - done <= 1; state <= DONE
- Timing:
  - Latency is exactly WIDTH clocks from the start-accept edge to the edge that raises done.
  - busy=1 during edges E0+1 .. E0+WIDTH inclusive of the RUN cycles; busy=0 in DONE.
- start while in RUN is ignored: no restart, operands unchanged.
- sum/cout change only at completion or reset. They are never visible mid-computation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); exact, no saturation.
- WIDTH=1: RUN lasts one cycle. The counter is sized $clog2(WIDTH)+1 bits so WIDTH=1 and powers of two do not wrap early.
- Reset mid-operation aborts immediately with the full reset state above. No done pulse is produced for the aborted operation.
- Input changes on a/b/cin after acceptance have no effect.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), captured with start
  - sub=1: computes a + ~b + 1; cin is ignored; B is inverted at capture and the carry FF is loaded with 1
  - cout=1 means no borrow (a >= b unsigned)
  - sub=0 behaves identically to the base block
- Undefined: no sub port; add only. All other behaviour and latency are identical.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse -> done exactly 8 clocks after the accept edge; sum=8'h00, cout=1; busy high for the 8 RUN cycles.
- WIDTH=8, a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0. Then pulse start again in the RUN cycle 3 -> ignored; result unchanged and done fires once.
- Back-to-back: start held high through the DONE cycle with a=8'h01, b=8'h02, cin=0 -> second op accepted without passing IDLE; second done 8 clocks later with sum=8'h03. The first result (prior sum) stays held until then.
- Reset abort: start a=8'hAA, b=8'h55; drop rst_n between clock edges after 4 RUN cycles -> busy/done/sum/cout go 0 immediately and asynchronously; no done pulse. After release, a new op 8'h10+8'h10 -> sum=8'h20.
- WIDTH=1 instance: a=1, b=1, cin=1 -> done 1 clock after accept, sum=1, cout=1.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0. Then sub=1, a=8'h20, b=8'h10 -> sum=8'h10, cout=1.

Source files
------------

// File: rtl/serial_adder_n.sv
// serial_adder_n -- bit-serial adder, one full-adder cell plus a carry FF.
// It adds two WIDTH-bit operands LSB-first, one bit per clock. The result is
// ready WIDTH clocks after start is accepted.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted only in IDLE or DONE
//   a, b   operands, captured on accept
//   cin    carry-in, captured on accept
//   sub    (only with SERIAL_ADDER_SUB_EN) 1 = a - b, captured on accept
//   busy   high while the serial add is running
//   done   one-cycle completion pulse
//   sum    registered result, held until the next completion
//   cout   registered carry-out (with sub: 1 = no borrow)
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so WIDTH=1 and powers of two cannot wrap early.
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry, carry_next, bit_sum;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Values loaded on accept. Subtraction inverts B and uses a carry of 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // Full-adder cell on the current LSBs.
  always_comb begin
    bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    // Shift the new bit into the result MSB; written this way so that
    // WIDTH=1 needs no zero-width slice.
    res_next            = res >> 1;
    res_next[WIDTH-1]   = bit_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= carry_next;
      res   <= res_next;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_next;
        cout <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    string      tag;
  } exp_t;

  logic       clk, rst_n;
  logic       start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub, sub1;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_adder_n #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_n #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 9-bit arithmetic; subtraction as a + ~b + 1.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Drive one request, push its expected result, return after the accept edge.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic s, input string tag, input bit push);
    logic [8:0] r;
    a = x; b = y; cin = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    r = model(x, y, c, s);
    if (push) sb.push_back('{sum: r[7:0], cout: r[8], tag: tag});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done after an accept edge; check latency, busy, hold,
  // then pop the scoreboard and compare. poke>0 pulses start in that RUN cycle.
  task automatic wait_result(input string tag, input int poke);
    int         n = 0, busy_n = 0, hold_bad = 0;
    bit         seen = 0;
    logic [7:0] held_s = sum;
    logic       held_c = cout;
    exp_t       e;
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'b1;
      end else if (poke != 0 && n == poke + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        if (sum !== held_s || cout !== held_c) hold_bad++;
      end
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, busy_n, 7);
    check({tag, "_held_midrun"}, hold_bad, 0);
    check({tag, "_busy_in_done"}, busy, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_sum"}, sum, e.sum);
      check({e.tag, "_cout"}, cout, e.cout);
    end
  endtask

  initial begin
    int extra;
    logic [7:0] ra, rb;
    logic [1:0] r1;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_w1_outs", {busy1, done1, sum1, cout1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FF + 01: full carry ripple
    issue(8'hFF, 8'h01, 1'b0, 1'b0, "ff_01", 1);
    check("ff_01_busy_after_accept", busy, 1);
    wait_result("ff_01", 0);

    // 5A + 3C + 1 with a start pulse in RUN cycle 3 that must be ignored
    issue(8'h5A, 8'h3C, 1'b1, 1'b0, "5a_3c", 1);
    wait_result("5a_3c", 3);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("5a_3c_single_done", extra, 0);

    // Back-to-back: start held through DONE; second operands set after
    // the first accept, which must not disturb the first op.
    a = 8'h33; b = 8'h44; cin = 1'b0;
    sb.push_back('{sum: 8'h77, cout: 1'b0, tag: "b2b_first"});
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; cin = 1'b0;
    wait_result("b2b_first", 0);
    sb.push_back('{sum: 8'h03, cout: 1'b0, tag: "b2b_second"});
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_idle_busy", busy, 1);
    check("b2b_prior_sum_held", sum, 8'h77);
    wait_result("b2b_second", 0);

    // Reset abort after 4 RUN cycles
    issue(8'hAA, 8'h55, 1'b0, 1'b0, "abort", 0);
    repeat (3) @(posedge clk);
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h10, 8'h10, 1'b0, 1'b0, "after_abort", 1);
    wait_result("after_abort", 0);

    // A few random operand sets
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      issue(ra, rb, 1'($urandom), 1'b0, "rand", 1);
      wait_result("rand", 0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20", 1);
    wait_result("sub_10_20", 0);
    issue(8'h20, 8'h10, 1'b1, 1'b1, "sub_20_10", 1);
    wait_result("sub_20_10", 0);
    issue(8'h5A, 8'h3C, 1'b1, 1'b0, "sub0_add", 1);
    wait_result("sub0_add", 0);
`endif

    // WIDTH=1 instance: one RUN cycle
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    r1 = 2'd3;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1_busy", busy1, 1);
    check("w1_done_early", done1, 0);
    @(posedge clk); #1;
    check("w1_done", done1, 1);
    check("w1_sum_cout", {cout1, sum1}, r1);

    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
    r1 = 2'd1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    check("w1b_done", done1, 1);
    check("w1b_sum_cout", {cout1, sum1}, r1);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
